switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Input-conditioning stage directly upstream of the switches game core.
- Takes raw, asynchronous, bouncing push-button/key pins and synchronizes and debounces each one independently.
- Presents a clean, zero-padded 8-bit switch vector for the core's player switch input, plus one-cycle press/release pulses.
- Instantiated in the board wrapper and clocked by the same divided game clock as the core, so every output is synchronous to the consumer.

Parameters:
- NUM_KEYS, 4, number of physical keys debounced; legal range 1..8.
- DEBOUNCE_CYCLES, 250000, consecutive cycles a new level must persist before it is accepted (10 ms at 25 MHz); must be >= 2.
- KEY_ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; the block inverts so all outputs are active-high.

Ports:
- clk  input  1  game clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion externally synchronized.
- keys  input  NUM_KEYS  raw key pins, asynchronous to clk.
- switches  output  8  debounced key levels, active-high; bits [NUM_KEYS-1:0] valid, upper bits tied 0.
- pressed  output  NUM_KEYS  one-cycle pulse when the key's debounced level goes 0->1.
- released  output  NUM_KEYS  one-cycle pulse when the key's debounced level goes 1->0.
- any_pressed  output  1  OR of pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both synchronizer stages load the inactive pin level: 1 if KEY_ACTIVE_LOW, else 0.
  - All counters clear to 0; all stable states clear to 0.
  - switches=8'h00; pressed, released and any_pressed = 0.
- Synchronizer: 2-flop chain per key. k[i] = sync2[i] XOR KEY_ACTIVE_LOW, so k is active-high.
- Per-key state: stable bit s[i] and counter cnt[i]. Counter width is ceil(log2(DEBOUNCE_CYCLES)) bits, as a localparam. Each rising edge:
  - k[i]==s[i]: cnt[i]<=0 and no pulse.
  - k[i]!=s[i] and cnt[i]==DEBOUNCE_CYCLES-1: s[i]<=k[i], cnt[i]<=0, and assert pressed[i] (if k[i]=1) or released[i] (if k[i]=0) for exactly one cycle.
  - Otherwise: cnt[i]<=cnt[i]+1.
- The counter never wraps; it is cleared before reaching DEBOUNCE_CYCLES.
- Latency: a pin change stable before rising edge E appears on switches and the pulse outputs after rising edge E+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges inclusive.
- pressed, released and switches update on the same edge. All outputs are registered.
- Glitch rejection: a difference lasting fewer than DEBOUNCE_CYCLES consecutive synchronized cycles clears the counter and never changes s.
- Bounce: any return to the stable level restarts the count from 0.
- Keys are fully independent. Simultaneous transitions on several keys yield simultaneous pulses, and any_pressed is asserted once.
- pressed[i] and released[i] are never high in the same cycle.
- Reset mid-count: all progress is discarded and no pulse is emitted. After release, the first acceptance needs a full DEBOUNCE_CYCLES window.
- A key held through reset: after reset release it is seen as a new press, with a pressed pulse after the full latency.
- Unused switches bits are constant 0 and never toggle.

Test Plan (DEBOUNCE_CYCLES=4, NUM_KEYS=4 unless noted):
- Reset check: hold reset=0 with keys=4'hF mid-sequence -> switches=8'h00 and all pulses 0 immediately (asynchronous), without waiting for a clock edge.
- Clean press: keys[0] 0->1 before edge E, held -> switches=8'h01 and pressed=4'b0001 for one cycle after edge E+5; released stays 0.
- Glitch rejection: keys[1] high for 3 cycles then low -> switches stays 8'h00 and no pulses. Then hold high for 4+ cycles -> pressed[1] pulses once.
- Bounce: keys[2] toggles 1,0,1,1,0,1,1,1,1 cycle by cycle -> exactly one pressed[2] pulse, after the final 4-cycle-stable run.
- Simultaneous press then release: keys 4'b0000->4'b1010 -> pressed=4'b1010 and any_pressed=1 in one cycle, switches=8'h0A. Then keys->4'b0000 -> released=4'b1010 in one cycle, switches=8'h00.
- KEY_ACTIVE_LOW=1: idle pins 4'hF -> switches=8'h00. Drive keys[3]=0 -> switches=8'h08 and pressed[3] pulses. Assert reset mid-count -> no pulse.

Source files
------------

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions raw push-button / key pins for the switches game core. Each pin
// passes through a two-flop synchronizer and is then debounced on its own: a
// new level is accepted only once it has persisted for DEBOUNCE_CYCLES
// consecutive clocks. When a level is accepted, the block emits a one-cycle
// pressed or released pulse on the same edge that updates the debounced level.
//
// Parameters
//   NUM_KEYS        number of keys debounced (1..8)
//   DEBOUNCE_CYCLES consecutive cycles a new level must persist (>= 2)
//   KEY_ACTIVE_LOW  1 = the pin reads 0 when the key is pressed
//
// Ports
//   clk          game clock; all state changes on the rising edge
//   reset        asynchronous active-low reset
//   keys         raw key pins, asynchronous to clk
//   switches     debounced active-high levels, zero-padded to 8 bits
//   pressed      one-cycle pulse when a debounced level rises
//   released     one-cycle pulse when a debounced level falls
//   any_pressed  OR of pressed, registered alongside it
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [7:0]          switches,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic                any_pressed
);

    localparam int                  CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Level a pin shows when its key is not pressed.
    localparam logic [NUM_KEYS-1:0] PIN_IDLE = KEY_ACTIVE_LOW ? {NUM_KEYS{1'b1}}
                                                              : {NUM_KEYS{1'b0}};

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] key_act;
    logic [NUM_KEYS-1:0] stable_q;
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] pressed_q;
    logic [NUM_KEYS-1:0] pressed_d;
    logic [NUM_KEYS-1:0] released_q;
    logic [NUM_KEYS-1:0] released_d;
    logic                any_pressed_q;

    // Both synchronizer stages reset to the idle pin level, so that a key
    // held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
        end
    end

    // Synchronized key levels converted to active-high.
    assign key_act = sync2_q ^ PIN_IDLE;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_n;
            logic             press_n;
            logic             release_n;

            // The counter tracks how many consecutive edges the synchronized
            // level has differed from the accepted level. Any agreement
            // restarts it, and acceptance clears it, so it never wraps.
            always_comb begin
                cnt_d     = cnt_q;
                stable_n  = stable_q[gi];
                press_n   = 1'b0;
                release_n = 1'b0;
                if (key_act[gi] == stable_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    stable_n  = key_act[gi];
                    press_n   = key_act[gi];
                    release_n = ~key_act[gi];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi]   = stable_n;
            assign pressed_d[gi]  = press_n;
            assign released_d[gi] = release_n;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q      <= '0;
            pressed_q     <= '0;
            released_q    <= '0;
            any_pressed_q <= 1'b0;
        end else begin
            stable_q      <= stable_d;
            pressed_q     <= pressed_d;
            released_q    <= released_d;
            any_pressed_q <= |pressed_d;
        end
    end

    // Switch bits beyond NUM_KEYS are hard-wired to 0.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_switch
            if (gi < NUM_KEYS) begin : g_used
                assign switches[gi] = stable_q[gi];
            end else begin : g_unused
                assign switches[gi] = 1'b0;
            end
        end
    endgenerate

    assign pressed     = pressed_q;
    assign released    = released_q;
    assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// Bench for switch_debouncer with DEBOUNCE_CYCLES=4 and NUM_KEYS=4.
// Instance A uses active-high pins; instance B uses active-low pins.
//
// Reference model: the bench keeps the last few raw pin samples, taken at
// each rising edge and expressed as active-high levels. The DUT acts on a
// sample two edges after it is taken. A key's accepted level flips when the
// DEBOUNCE_CYCLES most recent effective samples all differ from that level.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int DC = 4;
    localparam int NK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b;
    logic [NK-1:0] keys_a, keys_b;
    logic [7:0]    sw_a, sw_b;
    logic [NK-1:0] pr_a, pr_b, rl_a, rl_b;
    logic          any_a, any_b;

    int errors = 0;
    int checks = 0;

    switch_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .reset(rst_a), .keys(keys_a), .switches(sw_a),
        .pressed(pr_a), .released(rl_a), .any_pressed(any_a)
    );

    switch_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(rst_b), .keys(keys_b), .switches(sw_b),
        .pressed(pr_b), .released(rl_b), .any_pressed(any_b)
    );

    // ---------------- reference model ----------------
    // hist[0] holds the most recent raw sample (active-high). Just before
    // edge n, hist[m] holds the sample from edge n-1-m. The DUT acts at
    // edge n on the sample from edge n-2, which is hist[1], so the window
    // for the last DC edges is hist[1..DC].
    logic [NK-1:0] hist_a [0:DC];
    logic [NK-1:0] hist_b [0:DC];
    logic [NK-1:0] m_sw_a, m_pr_a, m_rl_a, flip_a;
    logic [NK-1:0] m_sw_b, m_pr_b, m_rl_b, flip_b;

    always_comb begin
        flip_a = '1;
        flip_b = '1;
        for (int m = 1; m <= DC; m++) begin
            flip_a = flip_a & (hist_a[m] ^ m_sw_a);
            flip_b = flip_b & (hist_b[m] ^ m_sw_b);
        end
    end

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            for (int j = 0; j <= DC; j++) hist_a[j] <= '0;
            m_sw_a <= '0; m_pr_a <= '0; m_rl_a <= '0;
        end else begin
            hist_a[0] <= keys_a;
            for (int j = 1; j <= DC; j++) hist_a[j] <= hist_a[j-1];
            m_sw_a <= m_sw_a ^ flip_a;
            m_pr_a <= flip_a & ~m_sw_a;
            m_rl_a <= flip_a & m_sw_a;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int j = 0; j <= DC; j++) hist_b[j] <= '0;
            m_sw_b <= '0; m_pr_b <= '0; m_rl_b <= '0;
        end else begin
            hist_b[0] <= ~keys_b;
            for (int j = 1; j <= DC; j++) hist_b[j] <= hist_b[j-1];
            m_sw_b <= m_sw_b ^ flip_b;
            m_pr_b <= flip_b & ~m_sw_b;
            m_rl_b <= flip_b & m_sw_b;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; keys_a = '0; keys_b = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sw_a, pr_a, rl_a, any_a, sw_b, pr_b, rl_b, any_b} !== '0) begin
            errors++;
            $display("FAIL reset_state: a sw=%h pr=%b rl=%b any=%b b sw=%h pr=%b rl=%b any=%b, required all 0",
                     sw_a, pr_a, rl_a, any_a, sw_b, pr_b, rl_b, any_b);
        end
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        keys_a = 4'hF;
        repeat (8) @(negedge clk);
        checks++;
        if (sw_a !== 8'h0F) begin
            errors++;
            $display("FAIL reset_prefill: sw=%h required 0f", sw_a);
        end
        // Assert reset between edges; outputs must clear with no edge.
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if ({sw_a, pr_a, rl_a, any_a} !== '0) begin
            errors++;
            $display("FAIL reset_async: sw=%h pr=%b rl=%b any=%b required 00/0000/0000/0",
                     sw_a, pr_a, rl_a, any_a);
        end
        @(negedge clk);
        keys_a = '0;
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        keys_a = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL press_model k=%0d: sw=%h pr=%b rl=%b any=%b required sw=%h pr=%b rl=%b any=%b",
                         k, sw_a, pr_a, rl_a, any_a, {4'h0, m_sw_a}, m_pr_a, m_rl_a, |m_pr_a);
            end
            checks++;
            if (sw_a !== ((k >= 5) ? 8'h01 : 8'h00) || pr_a !== ((k == 5) ? 4'b0001 : 4'b0000) || rl_a !== 4'b0000) begin
                errors++;
                $display("FAIL press_latency k=%0d: sw=%h pr=%b rl=%b", k, sw_a, pr_a, rl_a);
            end
        end
        keys_a = '0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL press_release_model: sw=%h pr=%b rl=%b required sw=%h pr=%b rl=%b",
                         sw_a, pr_a, rl_a, {4'h0, m_sw_a}, m_pr_a, m_rl_a);
            end
        end
        $display("test_clean_press done sw=%h", sw_a);
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int j = 0; j < 18; j++) begin
            keys_a = (j < 3 || j >= 8) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (pr_a[1]) pulses++;
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL glitch_model j=%0d: sw=%h pr=%b rl=%b required sw=%h pr=%b rl=%b",
                         j, sw_a, pr_a, rl_a, {4'h0, m_sw_a}, m_pr_a, m_rl_a);
            end
            if (j < 13) begin
                checks++;
                if (sw_a !== 8'h00 || pr_a !== 4'b0000 || rl_a !== 4'b0000) begin
                    errors++;
                    $display("FAIL glitch_reject j=%0d: sw=%h pr=%b rl=%b required 00/0000/0000", j, sw_a, pr_a, rl_a);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL glitch_press_count: pulses=%0d required 1", pulses);
        end
        keys_a = '0;
        repeat (8) @(negedge clk);
        $display("test_glitch done pulses=%0d", pulses);
    endtask

    task automatic test_bounce();
        logic [8:0] pat = 9'b111101101; // bit j is the level driven at step j
        int pulses = 0;
        int pulse_step = -1;
        for (int j = 0; j < 16; j++) begin
            keys_a = (j < 9) ? {1'b0, pat[j], 2'b00} : 4'b0100;
            @(negedge clk);
            if (pr_a[2]) begin
                pulses++;
                pulse_step = j;
            end
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL bounce_model j=%0d: sw=%h pr=%b rl=%b required sw=%h pr=%b rl=%b",
                         j, sw_a, pr_a, rl_a, {4'h0, m_sw_a}, m_pr_a, m_rl_a);
            end
        end
        checks++;
        if (pulses != 1 || pulse_step != 10) begin
            errors++;
            $display("FAIL bounce_pulse: count=%0d step=%0d required count=1 step=10", pulses, pulse_step);
        end
        keys_a = '0;
        repeat (8) @(negedge clk);
        $display("test_bounce done pulses=%0d step=%0d", pulses, pulse_step);
    endtask

    task automatic test_simultaneous();
        int pr_hits = 0, any_hits = 0, rl_hits = 0;
        keys_a = 4'b1010;
        repeat (8) begin
            @(negedge clk);
            if (pr_a == 4'b1010) pr_hits++;
            if (any_a) any_hits++;
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL simul_press_model: sw=%h pr=%b any=%b required sw=%h pr=%b any=%b",
                         sw_a, pr_a, any_a, {4'h0, m_sw_a}, m_pr_a, |m_pr_a);
            end
        end
        checks++;
        if (pr_hits != 1 || any_hits != 1 || sw_a !== 8'h0A) begin
            errors++;
            $display("FAIL simul_press: pr_cycles=%0d any_cycles=%0d sw=%h required 1 1 0a", pr_hits, any_hits, sw_a);
        end
        keys_a = 4'b0000;
        repeat (8) begin
            @(negedge clk);
            if (rl_a == 4'b1010) rl_hits++;
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a}) begin
                errors++;
                $display("FAIL simul_release_model: sw=%h rl=%b required sw=%h rl=%b",
                         sw_a, rl_a, {4'h0, m_sw_a}, m_rl_a);
            end
        end
        checks++;
        if (rl_hits != 1 || sw_a !== 8'h00) begin
            errors++;
            $display("FAIL simul_release: rl_cycles=%0d sw=%h required 1 00", rl_hits, sw_a);
        end
        $display("test_simultaneous done pr=%0d rl=%0d", pr_hits, rl_hits);
    endtask

    task automatic test_random();
        int hold [NK];
        int presses = 0;
        for (int i = 0; i < NK; i++) hold[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    keys_a[i] = 1'($urandom_range(0, 1));
                    hold[i]   = int'($urandom_range(1, 7));
                end
                hold[i]--;
            end
            @(negedge clk);
            if (any_a) presses++;
            checks++;
            if ({sw_a, pr_a, rl_a, any_a} !== {4'h0, m_sw_a, m_pr_a, m_rl_a, |m_pr_a} || (pr_a & rl_a) !== 4'b0000) begin
                errors++;
                $display("FAIL random_model c=%0d: sw=%h pr=%b rl=%b any=%b required sw=%h pr=%b rl=%b any=%b",
                         c, sw_a, pr_a, rl_a, any_a, {4'h0, m_sw_a}, m_pr_a, m_rl_a, |m_pr_a);
            end
        end
        keys_a = '0;
        repeat (8) @(negedge clk);
        $display("test_random done press_cycles=%0d", presses);
    endtask

    task automatic test_active_low();
        int pulses = 0;
        int pulse_step = -1;
        keys_b = 4'hF;
        repeat (4) @(negedge clk);
        checks++;
        if (sw_b !== 8'h00) begin
            errors++;
            $display("FAIL al_idle: sw=%h required 00", sw_b);
        end
        keys_b = 4'b0111;
        repeat (8) begin
            @(negedge clk);
            if (pr_b[3]) pulses++;
            checks++;
            if ({sw_b, pr_b, rl_b, any_b} !== {4'h0, m_sw_b, m_pr_b, m_rl_b, |m_pr_b}) begin
                errors++;
                $display("FAIL al_press_model: sw=%h pr=%b rl=%b required sw=%h pr=%b rl=%b",
                         sw_b, pr_b, rl_b, {4'h0, m_sw_b}, m_pr_b, m_rl_b);
            end
        end
        checks++;
        if (pulses != 1 || sw_b !== 8'h08) begin
            errors++;
            $display("FAIL al_press: pulses=%0d sw=%h required 1 08", pulses, sw_b);
        end
        keys_b = 4'hF;
        repeat (8) @(negedge clk);
        // Start a press, then reset before it can be accepted.
        keys_b = 4'b0111;
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({sw_b, pr_b, rl_b, any_b} !== '0) begin
            errors++;
            $display("FAIL al_reset_midcount: sw=%h pr=%b rl=%b any=%b required all 0", sw_b, pr_b, rl_b, any_b);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        pulses = 0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (pr_b[3]) begin
                pulses++;
                pulse_step = j;
            end
            checks++;
            if ({sw_b, pr_b, rl_b, any_b} !== {4'h0, m_sw_b, m_pr_b, m_rl_b, |m_pr_b}) begin
                errors++;
                $display("FAIL al_after_reset_model j=%0d: sw=%h pr=%b required sw=%h pr=%b",
                         j, sw_b, pr_b, {4'h0, m_sw_b}, m_pr_b);
            end
        end
        checks++;
        if (pulses != 1 || pulse_step != 5) begin
            errors++;
            $display("FAIL al_held_through_reset: count=%0d step=%0d required count=1 step=5", pulses, pulse_step);
        end
        keys_b = 4'hF;
        repeat (8) @(negedge clk);
        $display("test_active_low done sw=%h", sw_b);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; keys_a = '0; keys_b = '1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_random();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
